// File: rtl/master_bus_arbiter_pkg.sv
// Shared types and helpers for the N-master bus arbiter.
// Pure declarations: no latency or backpressure of its own.
package master_bus_arbiter_pkg;

  localparam int MAX_BUS_MASTERS = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Zero input maps to index 0; callers qualify with their own busy/valid flag.
  function automatic int onehot_to_idx(input logic [MAX_BUS_MASTERS-1:0] oneHot);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_BUS_MASTERS; i++) begin
      if (oneHot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/master_bus_arbiter_rr_priority_picker.sv
// Rotating-priority picker: first requester found searching upward from ptr, wrapping.
// Purely combinational, zero latency; no backpressure (winner is all zeros when req is zero).
module rr_priority_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winnerIdx
);

  logic found;

  always_comb begin
    winner    = '0;
    winnerIdx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found                        = 1'b1;
        winner[(int'(ptr) + i) % N]  = 1'b1;
        winnerIdx                    = IDX_W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/master_bus_arbiter.sv
// N-master to 1-slave arbiter holding the grant for a whole transaction, with a stall watchdog.
// Request-to-slaveCmdValid latency 1 cycle; one idle bubble after each completion, abort or timeout.
module master_bus_arbiter
  import master_bus_arbiter_pkg::*;
#(
  parameter int  NUM_MASTERS = 2,
  parameter type TCmd        = logic,
  parameter type TResult     = logic,
  parameter int  ROUND_ROBIN = 1,
  parameter int  TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  TCmd                    masterCmd [NUM_MASTERS],
  input  logic [NUM_MASTERS-1:0] masterCmdValid,
  output TResult                 masterResult [NUM_MASTERS],
  output logic [NUM_MASTERS-1:0] masterDone,
  output TCmd                    slaveCmd,
  output logic                   slaveCmdValid,
  input  TResult                 slaveResult,
  input  logic                   slaveDone,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   timeoutErr
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t             state, stateNext;
  logic [NUM_MASTERS-1:0] grantNext;
  logic [IDX_W-1:0]       ptr, ptrNext;
  logic [CNT_W-1:0]       wdCount, wdCountNext;

  logic [IDX_W-1:0]       ownerIdx;
  logic [IDX_W-1:0]       pickPtr;
  logic [NUM_MASTERS-1:0] pickWinner;
  logic [IDX_W-1:0]       pickIdx;
  logic                   busy;
  logic                   xferDone;
  logic                   abort;
  logic                   wdHit;
  logic [IDX_W-1:0]       rotPtr;

  // Fixed priority is just the rotating picker with its search start pinned to master 0.
  assign pickPtr = (ROUND_ROBIN != 0) ? ptr : '0;

  rr_priority_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) uPicker (
    .req       (masterCmdValid),
    .ptr       (pickPtr),
    .winner    (pickWinner),
    .winnerIdx (pickIdx)
  );

  assign ownerIdx = IDX_W'(onehot_to_idx(MAX_BUS_MASTERS'(grant)));
  assign busy     = (state == ARB_BUSY);
  assign xferDone = busy && slaveDone;
  assign abort    = busy && !slaveDone && !masterCmdValid[ownerIdx];
  assign wdHit    = (TIMEOUT > 0) && busy && !slaveDone && (wdCount == WD_LAST);
  assign rotPtr   = (ownerIdx == LAST_IDX) ? '0 : ownerIdx + 1'b1;

  assign slaveCmd      = busy ? masterCmd[ownerIdx] : '0;
  assign slaveCmdValid = busy && masterCmdValid[ownerIdx];
  assign masterDone    = xferDone ? grant : '0;
  assign timeoutErr    = wdHit;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      masterResult[i] = (xferDone && grant[i]) ? slaveResult : '0;
    end
  end

  always_comb begin
    stateNext   = state;
    grantNext   = grant;
    ptrNext     = ptr;
    wdCountNext = wdCount;
    case (state)
      ARB_IDLE: begin
        if (|masterCmdValid) begin
          stateNext   = ARB_BUSY;
          grantNext   = pickWinner;
          wdCountNext = '0;
        end
      end
      ARB_BUSY: begin
        // Done wins over a simultaneous valid drop, so completion is checked first.
        if (xferDone || abort || wdHit) begin
          stateNext = ARB_IDLE;
          grantNext = '0;
          ptrNext   = (ROUND_ROBIN != 0) ? rotPtr : '0;
        end else if (wdCount != '1) begin
          wdCountNext = wdCount + 1'b1;
        end
      end
      default: begin
        stateNext = ARB_IDLE;
        grantNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      grant   <= '0;
      ptr     <= '0;
      wdCount <= '0;
    end else begin
      state   <= stateNext;
      grant   <= grantNext;
      ptr     <= ptrNext;
      wdCount <= wdCountNext;
    end
  end

  grantOneHot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  doneOneHot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(masterDone));
  doneOwned:   assert property (@(posedge clk) disable iff (!rst_n) (masterDone & ~grant) == '0);
  pickSane:    assert property (@(posedge clk) disable iff (!rst_n)
                                (|masterCmdValid) |-> pickWinner[pickIdx]);

endmodule

// File: doc/master_bus_arbiter.md
Name: master_bus_arbiter

Overview:
- Parametrised N-master to 1-slave bus arbiter for the SoC interconnect. Successor to the single-select two-master mux.
- Arbitration is internal, round-robin or fixed-priority. The grant is held for a whole transaction. A watchdog releases the bus if a slave stalls.
- Sits between the core's instruction/data/debug masters and the shared memory/peripheral bus.

Parameters:
- NUM_MASTERS, 2, number of master ports (1..8).
- TCmd, logic, command bundle type (passed through unmodified).
- TResult, logic, result bundle type (passed through unmodified).
- ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority, index 0 highest.
- TIMEOUT, 64, maximum cycles in BUSY before forced release; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- masterCmd  in  NUM_MASTERS x TCmd  per-master command.
- masterCmdValid  in  NUM_MASTERS  per-master request.
- masterResult  out  NUM_MASTERS x TResult  per-master result.
- masterDone  out  NUM_MASTERS  per-master one-cycle completion pulse.
- slaveCmd  out  TCmd  command to the shared bus.
- slaveCmdValid  out  1  shared-bus request.
- slaveResult  in  TResult  shared-bus result.
- slaveDone  in  1  shared-bus completion, one cycle.
- grant  out  NUM_MASTERS  one-hot current owner; all zeros when idle.
- timeoutErr  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE, grant is 0, priority pointer is 0, watchdog counter is 0.
  - slaveCmdValid, masterDone and timeoutErr are 0. slaveCmd, masterResult and slaveCmd payload are '0.
  - Reset mid-transaction abandons the transaction with no done pulse.
- State IDLE:
  - slaveCmdValid=0 and slaveCmd='0.
  - If any masterCmdValid is set, the picker chooses a winner. The winner's grant bit registers on that edge and the state moves to BUSY.
  - Latency from request to slaveCmdValid is exactly 1 cycle.
- State BUSY:
  - slaveCmd = masterCmd[owner] and slaveCmdValid = masterCmdValid[owner], both combinational.
  - Non-owner request changes are ignored.
- Completion:
  - In a BUSY cycle with slaveDone=1, masterDone[owner]=1 and masterResult[owner]=slaveResult in the same cycle.
  - All other masterResult entries stay '0 at all times.
  - The next state is IDLE, giving one bubble cycle between transactions.
- Round-robin pointer:
  - Updates to (owner+1) mod NUM_MASTERS on completion, abort or timeout. Search starts at the pointer and wraps.
  - With ROUND_ROBIN=0 the pointer is fixed at 0.
- Abort: if masterCmdValid[owner] drops in BUSY without slaveDone in the same cycle, the state returns to IDLE next cycle with no masterDone.
- Simultaneous events: slaveDone together with a valid drop counts as completion.
- Watchdog:
  - The counter clears on entry to BUSY and increments each BUSY cycle without slaveDone.
  - When count = TIMEOUT-1 and slaveDone=0, timeoutErr pulses, the state goes to IDLE, and there is no masterDone.
  - A slaveDone arriving while IDLE is ignored.
- Width rules:
  - Owner index width is max(1,$clog2(NUM_MASTERS)).
  - Counter width is max(1,$clog2(TIMEOUT+1)). The counter saturates and never wraps.
- NUM_MASTERS=1: the master always wins and behaves as a registered pass-through with the watchdog.
- Invariants (assertions): grant is one-hot or zero; masterDone is one-hot or zero; a masterDone bit is set only where grant is set.

Decomposition:
- Common package gets:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY}.
  - MAX_BUS_MASTERS=8.
  - Function onehot_to_idx.
- One sub-module, rr_priority_picker: combinational, inputs req[N] and ptr, outputs one-hot winner and winner index. Used by both modes (ptr tied to 0 for fixed priority).

Test Plan:
- Reset mid-BUSY: N=2, master1 granted, rst_n low for 1 cycle → grant=00, slaveCmdValid=0 immediately (async), no masterDone; after release, IDLE.
- Single request: master0 valid at cycle 0 → grant=01 at cycle 1, slaveCmd=masterCmd[0]; slaveDone at cycle 4 → masterDone=01 at cycle 4 with slaveResult copied, grant=00 at cycle 5.
- Round-robin fairness: N=4, all valid continuously, slaveDone 2 cycles after each grant → grant order 0,1,2,3,0, each separated by one idle cycle.
- Fixed priority: ROUND_ROBIN=0, masters 1 and 3 both always valid → master 1 wins every time; master 3 granted only once master 1 drops.
- Abort: owner drops valid in BUSY with slaveDone=0 → IDLE next cycle, no masterDone, pointer advances.
- Timeout: TIMEOUT=8, slaveDone never asserted → timeoutErr pulse on the 8th BUSY cycle, grant=0 the following cycle; a late slaveDone produces no masterDone.
